// File: rtl/codificador_jogada.sv
// Move encoder: synchronizes and debounces six buttons, then issues one-hot moves with a valid/accept handshake.
// Optional auto-repeat of held movement buttons is enabled by defining REPETICAO_AUTOMATICA_EN.
module codificador_jogada #(
    parameter int unsigned DEBOUNCE_CICLOS  = 4,
    parameter int unsigned REPETICAO_CICLOS = 100
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] botoes,
    input  logic       jogada_aceita,
    output logic [5:0] jogada,
    output logic       jogada_valida,
    output logic [5:0] db_botoes_filtrados,
    output logic [1:0] db_estado
);

    typedef enum logic [1:0] {
        OCIOSO   = 2'b00,
        PENDENTE = 2'b01,
        SOLTAR   = 2'b10
    } estado_t;

    localparam logic [7:0] DB_LIMITE = 8'(DEBOUNCE_CICLOS - 1);

    localparam bit PARAMETROS_OK = (DEBOUNCE_CICLOS >= 2) && (DEBOUNCE_CICLOS <= 255) &&
                                   (REPETICAO_CICLOS >= 2) && (REPETICAO_CICLOS <= 65535);

    generate
        if (!PARAMETROS_OK) begin : g_parametros_invalidos
            $error("codificador_jogada: DEBOUNCE_CICLOS or REPETICAO_CICLOS out of range");
        end
    endgenerate

    logic [5:0] sinc1_q, sinc1_d;
    logic [5:0] sinc2_q, sinc2_d;
    logic [5:0] filt_q, filt_d;
    logic [5:0] filt_ant_q, filt_ant_d;
    logic [7:0] cont_q [6];
    logic [7:0] cont_d [6];
    logic [5:0] jogada_q, jogada_d;
    estado_t    estado_q, estado_d;
    logic [5:0] subida;

`ifdef REPETICAO_AUTOMATICA_EN
    localparam logic [15:0] REP_LIMITE = 16'(REPETICAO_CICLOS - 1);
    logic [15:0] temporizador_q, temporizador_d;
    logic        movimento_unico;
`endif

    // Fixed priority: shot > special > up > down > right > left.
    function automatic logic [5:0] prioridade(input logic [5:0] r);
        logic [5:0] sel;
        sel = '0;
        if (r[0])      sel = 6'b000001;
        else if (r[1]) sel = 6'b000010;
        else if (r[5]) sel = 6'b100000;
        else if (r[4]) sel = 6'b010000;
        else if (r[3]) sel = 6'b001000;
        else if (r[2]) sel = 6'b000100;
        return sel;
    endfunction

    always_comb begin
        sinc1_d = botoes;
        sinc2_d = sinc1_q;
        filt_d  = filt_q;
        for (int unsigned i = 0; i < 6; i++) begin
            cont_d[i] = '0;
            if (sinc2_q[i] != filt_q[i]) begin
                if (cont_q[i] == DB_LIMITE) begin
                    filt_d[i] = sinc2_q[i];
                end else begin
                    cont_d[i] = cont_q[i] + 8'd1;
                end
            end
        end
    end

    // Rises are taken from the registered filtered state, adding one edge after the filter flips.
    assign subida = filt_q & ~filt_ant_q;

`ifdef REPETICAO_AUTOMATICA_EN
    assign movimento_unico = $onehot(filt_q[5:2]);
`endif

    always_comb begin
        estado_d   = estado_q;
        jogada_d   = jogada_q;
        filt_ant_d = filt_q;
`ifdef REPETICAO_AUTOMATICA_EN
        temporizador_d = '0;
`endif
        unique case (estado_q)
            OCIOSO: begin
                if (subida != '0) begin
                    estado_d = PENDENTE;
                    jogada_d = prioridade(subida);
                end
            end
            PENDENTE: begin
                if (jogada_aceita) begin
                    estado_d = SOLTAR;
                    jogada_d = '0;
                end
            end
            SOLTAR: begin
                if (filt_q == '0) begin
                    estado_d = OCIOSO;
                end
`ifdef REPETICAO_AUTOMATICA_EN
                else if (movimento_unico && (filt_q == filt_ant_q)) begin
                    if (temporizador_q == REP_LIMITE) begin
                        estado_d = PENDENTE;
                        jogada_d = {filt_q[5:2], 2'b00};
                    end else begin
                        temporizador_d = temporizador_q + 16'd1;
                    end
                end
`endif
            end
            default: begin
                estado_d = OCIOSO;
                jogada_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sinc1_q    <= '0;
            sinc2_q    <= '0;
            filt_q     <= '0;
            filt_ant_q <= '0;
            cont_q     <= '{default: '0};
            jogada_q   <= '0;
            estado_q   <= OCIOSO;
        end else begin
            sinc1_q    <= sinc1_d;
            sinc2_q    <= sinc2_d;
            filt_q     <= filt_d;
            filt_ant_q <= filt_ant_d;
            cont_q     <= cont_d;
            jogada_q   <= jogada_d;
            estado_q   <= estado_d;
        end
    end

`ifdef REPETICAO_AUTOMATICA_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            temporizador_q <= '0;
        end else begin
            temporizador_q <= temporizador_d;
        end
    end
`endif

    assign jogada              = jogada_q;
    assign jogada_valida       = |jogada_q;
    assign db_botoes_filtrados = filt_q;
    assign db_estado           = estado_q;

endmodule
